// File: rtl/spin_encoder_if.sv
// spin_encoder_if
// Groups the player-control inputs and the dial-angle output of spin_encoder.
//
// Signals:
//   fast     : selects the fast digital step
//   minus    : rotate counter-clockwise (button)
//   plus     : rotate clockwise (button)
//   strobe   : frame tick; its rising edge triggers one digital step
//   spin_in  : HPS spinner; bit 8 toggles per new sample, [7:0] signed delta
//   spin_out : dial angle (integer part of the accumulator)
//
// Modports:
//   master : the side that drives the controls and reads the angle
//   slave  : the encoder itself
//
// Event semantics: there is no valid/ready pair. A digital event is the
// first clock with strobe=1 after a clock with strobe=0. An analog event is
// any clock in which spin_in[8] differs from its value one clock earlier.
// Each event is consumed exactly once, and spin_out reflects it one clock later.
interface spin_encoder_if #(
    parameter int OUT_W = 4
);
    logic             fast;
    logic             minus;
    logic             plus;
    logic             strobe;
    logic [8:0]       spin_in;
    logic [OUT_W-1:0] spin_out;

    modport master (
        output fast, minus, plus, strobe, spin_in,
        input  spin_out
    );

    modport slave (
        input  fast, minus, plus, strobe, spin_in,
        output spin_out
    );
endinterface

// File: rtl/spin_encoder.sv
// spin_encoder
// Merges digital rotate buttons (one step per frame strobe) and analog HPS
// spinner deltas into one wrapping fixed-point accumulator. The integer part
// of the accumulator is the absolute dial angle presented to the CPU.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : spin_encoder_if.slave (fast, minus, plus, strobe, spin_in -> spin_out)
//
// Optional feature: define SPIN_ENCODER_ACCEL_EN to add a hold counter that
// switches to the fast step after ACCEL_FRAMES consecutive same-direction
// strobes. Without the macro only `fast` selects the fast step.
module spin_encoder #(
    parameter int OUT_W        = 4,
    parameter int FRAC_W       = 3,
    parameter int FAST_SHIFT   = 2,
    parameter int SPIN_SHIFT   = 2,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic            clk,
    input  logic            reset,
    spin_encoder_if.slave   bus
);
    localparam int ACC_W = OUT_W + FRAC_W;
    // Wide enough that sign extension never loses the delta's sign bit.
    localparam int EXT_W = ACC_W + 8;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] dstep;
    logic [ACC_W-1:0] astep;
    logic [ACC_W-1:0] mag;
    logic [EXT_W-1:0] spin_ext;
    logic             strobe_d;
    logic             tog_d;
    logic             rise;
    logic             tog;
    logic             dir_up;
    logic             dir_dn;
    logic             accel_hit;

    assign rise   = bus.strobe & ~strobe_d;
    assign tog    = bus.spin_in[8] ^ tog_d;
    // Both buttons together cancel out.
    assign dir_up = bus.plus & ~bus.minus;
    assign dir_dn = bus.minus & ~bus.plus;

    assign spin_ext = {{(EXT_W-8){bus.spin_in[7]}}, bus.spin_in[7:0]};

`ifdef SPIN_ENCODER_ACCEL_EN
    localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);

    logic [HOLD_W-1:0] hold_cnt;
    // Last nonzero direction: 2'b01 up, 2'b10 down, 2'b00 none since reset.
    // With no history yet, a held button counts as continuing, so the very
    // first strobe of a hold already counts toward acceleration.
    logic [1:0]        last_dir;
    logic [1:0]        cur_dir;
    logic              same_dir;

    assign cur_dir   = {dir_dn, dir_up};
    assign same_dir  = (cur_dir != 2'b00) &&
                       ((last_dir == 2'b00) || (cur_dir == last_dir));
    // Uses the count from before this strobe's update.
    assign accel_hit = (hold_cnt == HOLD_W'(ACCEL_FRAMES));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            last_dir <= 2'b00;
        end else if (rise) begin
            if (same_dir) begin
                if (!accel_hit) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end else begin
                hold_cnt <= '0;
            end
            if (cur_dir != 2'b00) begin
                last_dir <= cur_dir;
            end
        end
    end
`else
    assign accel_hit = 1'b0;
`endif

    always_comb begin
        mag   = (bus.fast || accel_hit) ? ACC_W'(1 << FAST_SHIFT) : ACC_W'(1);
        dstep = '0;
        astep = '0;
        if (rise) begin
            if (dir_up) begin
                dstep = mag;
            end else if (dir_dn) begin
                dstep = ACC_W'(0) - mag;
            end
        end
        // Oversized scaled deltas simply wrap modulo 2^ACC_W.
        if (tog) begin
            astep = ACC_W'(spin_ext << SPIN_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        // Edge history tracks inputs even in reset so release is glitch-free.
        strobe_d <= bus.strobe;
        tog_d    <= bus.spin_in[8];
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc + dstep + astep;
        end
    end

    assign bus.spin_out = acc[ACC_W-1:FRAC_W];
endmodule

// File: tb/tb_spin_encoder.sv
// tb_spin_encoder
// Directed bench for spin_encoder. Drivers apply controls one time unit after
// the rising edge and queue the expected angle; a monitor on the falling
// edge pops every queued expectation and compares it with spin_out.
module tb_spin_encoder;
    localparam int OUT_W        = 4;
    localparam int ACCEL_FRAMES = 16;

    logic clk;
    logic reset;

    spin_encoder_if #(.OUT_W(OUT_W)) bus();

    spin_encoder #(
        .OUT_W(OUT_W),
        .FRAC_W(3),
        .FAST_SHIFT(2),
        .SPIN_SHIFT(2),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [OUT_W-1:0] exp_v;
    string            exp_name;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_v    = exp_q.pop_front();
            exp_name = name_q.pop_front();
            n_cmp++;
            if (bus.spin_out !== exp_v) begin
                n_err++;
                $display("FAIL %s: spin_out=%h expected %h", exp_name, bus.spin_out, exp_v);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [6:0] m_acc;
    int         m_hold;
    int         m_last;

    task automatic model_reset();
        m_acc  = '0;
        m_hold = 0;
        m_last = 0;
    endtask

    // Applies one strobe rise with the buttons currently driven.
    task automatic model_rise();
        int d;
        int mag;
        bit use_fast;
        d = (bus.plus && !bus.minus) ? 1 : ((bus.minus && !bus.plus) ? -1 : 0);
        use_fast = bus.fast;
`ifdef SPIN_ENCODER_ACCEL_EN
        if (m_hold == ACCEL_FRAMES) use_fast = 1'b1;
        if (d != 0 && (m_last == 0 || d == m_last)) begin
            if (m_hold < ACCEL_FRAMES) m_hold++;
        end else begin
            m_hold = 0;
        end
        if (d != 0) m_last = d;
`endif
        mag   = use_fast ? 4 : 1;
        m_acc = m_acc + 7'(d * mag);
    endtask

    task automatic model_spin(input logic [7:0] delta);
        int sd;
        sd    = int'($signed(delta));
        m_acc = m_acc + 7'(sd * 4);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [OUT_W-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One strobe pulse; expectation queued right after the updating edge.
    task automatic strobe_pulse(input string nm);
        bus.strobe = 1'b1;
        model_rise();
        tick();
        expect_out(nm, m_acc[6:3]);
        bus.strobe = 1'b0;
        tick();
    endtask

    task automatic spin_sample(input logic [7:0] delta);
        bus.spin_in = {~bus.spin_in[8], delta};
        model_spin(delta);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        bus.fast    = 1'b0;
        bus.minus   = 1'b0;
        bus.plus    = 1'b0;
        bus.strobe  = 1'b0;
        bus.spin_in = 9'h000;
        model_reset();

        // Reset with spinner toggles and strobe high; release must stay quiet.
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.spin_in = {~bus.spin_in[8], 8'h7F};
            tick();
        end
        bus.strobe = 1'b1;
        tick();
        expect_out("reset_state", 4'h0);
        reset = 1'b0;
        tick();
        expect_out("release_no_spurious", 4'h0);
        tick();
        expect_out("release_settled", 4'h0);
        bus.strobe = 1'b0;
        tick();

        // Idle strobes.
        for (int i = 0; i < 50; i++) strobe_pulse("idle");
        expect_out("idle_final", 4'h0);

        // Reset mid-frame discards the partial fraction.
        bus.plus = 1'b1;
        for (int i = 0; i < 3; i++) strobe_pulse("frac_build");
        do_reset();
        for (int i = 0; i < 5; i++) strobe_pulse("frac_after_reset");
        expect_out("frac_discarded", 4'h0);

        // Slow step and wrap.
        do_reset();
        for (int i = 1; i <= 128; i++) begin
            strobe_pulse("slow_step");
`ifndef SPIN_ENCODER_ACCEL_EN
            if (i == 8)   expect_out("slow_8", 4'h1);
            if (i == 128) expect_out("slow_wrap_128", 4'h0);
`endif
        end

        // Long strobe counts once.
        do_reset();
        bus.strobe = 1'b1;
        model_rise();
        repeat (100) tick();
        bus.strobe = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) strobe_pulse("long_follow");
        expect_out("long_strobe_7", 4'h0);
        strobe_pulse("long_follow");
        expect_out("long_strobe_8", 4'h1);

        // Fast and negative wrap; both buttons cancel.
        do_reset();
        bus.plus  = 1'b0;
        bus.minus = 1'b1;
        bus.fast  = 1'b1;
        strobe_pulse("fast_minus");
        expect_out("fast_neg_wrap", 4'hF);
        bus.plus = 1'b1;
        strobe_pulse("both_buttons");
        expect_out("both_no_move", 4'hF);
        bus.minus = 1'b0;
        strobe_pulse("fast_plus");
        expect_out("fast_back_to_zero", 4'h0);
        bus.plus = 1'b0;
        bus.fast = 1'b0;

        // Analog deltas.
        do_reset();
        spin_sample(8'h03);
        expect_out("spin_plus3", 4'h1);
        spin_sample(8'hFB);
        expect_out("spin_minus5", 4'hF);
        bus.spin_in[7:0] = 8'h40;
        tick();
        expect_out("spin_no_toggle", 4'hF);
        tick();
        expect_out("spin_no_toggle_hold", 4'hF);
        spin_sample(8'h02);
        expect_out("spin_plus2_wrap", 4'h0);

        // Simultaneous strobe rise and spinner toggle.
        do_reset();
        bus.plus   = 1'b1;
        bus.strobe = 1'b1;
        bus.spin_in = {~bus.spin_in[8], 8'h01};
        model_rise();
        model_spin(8'h01);
        tick();
        expect_out("simul_acc5", 4'h0);
        bus.strobe = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) strobe_pulse("simul_follow");
        expect_out("simul_acc8", 4'h1);

        // Acceleration.
        do_reset();
        bus.plus = 1'b1;
        bus.fast = 1'b0;
        for (int i = 0; i < 20; i++) strobe_pulse("accel_hold");
`ifdef SPIN_ENCODER_ACCEL_EN
        expect_out("accel_20", 4'h4);
`else
        expect_out("accel_20", 4'h2);
`endif
        bus.plus = 1'b0;
        strobe_pulse("accel_release");
        bus.plus = 1'b1;
        for (int i = 0; i < 7; i++) strobe_pulse("accel_rehold");
`ifdef SPIN_ENCODER_ACCEL_EN
        expect_out("accel_rehold_slow", 4'h4);
`else
        expect_out("accel_rehold_slow", 4'h3);
`endif
        bus.plus = 1'b0;

        // Drain and report.
        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
